// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - FP12 format defaults, derived widths and shared types for the vector-add arbiter
package fp_pkg;

  localparam int DEF_EXP_BITS  = 5;
  localparam int DEF_MANT_BITS = 6;
  localparam int DEF_W         = DEF_EXP_BITS + DEF_MANT_BITS + 1;
  localparam int DEF_VW        = 4 * DEF_W;

  localparam logic [DEF_W-1:0] FP12_ONE   = 12'h3C0;
  localparam logic [DEF_W-1:0] FP12_TWO   = 12'h400;
  localparam logic [DEF_W-1:0] FP12_THREE = 12'h420;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} lock_state_t;

  // Requester-index width, never narrower than one bit
  function automatic int id_width(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant with an optional locked-requester override
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic            lock_en,
  input  logic [ID_W-1:0] lock_id,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);

  logic [ID_W-1:0] idx;
  logic            found;

  // Locked requester wins outright while it is requesting; otherwise the first request at or after ptr
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    if (lock_en && req[lock_id]) begin
      grant[lock_id] = 1'b1;
      grant_id       = lock_id;
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = ID_W'((int'(ptr) + k) % N);
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_id   = idx;
        end
      end
    end
  end

endmodule

// File: rtl/fp_vadd_arbiter.sv
// rtl/fp_vadd_arbiter.sv - shares one 4-lane FP vector adder between requesters, tagging results with the issuer
module fp_vadd_arbiter
  import fp_pkg::*;
#(
  parameter int  NUM_REQ     = 4,
  parameter int  EXP_BITS    = DEF_EXP_BITS,
  parameter int  MANT_BITS   = DEF_MANT_BITS,
  parameter int  ADD_LATENCY = 2,
  parameter int  MAX_BURST   = 4,
  localparam int W           = EXP_BITS + MANT_BITS + 1,
  localparam int VW          = 4 * W,
  localparam int ID_W        = id_width(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_lock,
  input  logic [NUM_REQ*VW-1:0] req_x,
  input  logic [NUM_REQ*VW-1:0] req_y,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  add_in_valid,
  output logic [VW-1:0]         add_x,
  output logic [VW-1:0]         add_y,
  input  logic                  add_out_valid,
  input  logic [VW-1:0]         add_out,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [VW-1:0]         rsp_data,
  output logic                  busy,
  output logic                  err_orphan
);

  localparam int              BC_W    = $clog2(MAX_BURST + 1);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  lock_state_t            lock_state;
  logic [ID_W-1:0]        lock_id;
  logic [BC_W-1:0]        burst_cnt;
  logic [ID_W-1:0]        rr_ptr;
  logic [NUM_REQ-1:0]     req_gated;
  logic [NUM_REQ-1:0]     grant;
  logic [ID_W-1:0]        grant_id;
  logic                   accept;
  logic [ID_W-1:0]        iss_id;
  logic [ADD_LATENCY-1:0] tag_v;
  logic [ID_W-1:0]        tag_id [ADD_LATENCY];
  logic                   tail_v;
  logic [ID_W-1:0]        tail_id;

  // With en low nobody is granted, so in-flight work simply drains
  assign req_gated = en ? req_valid : '0;

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_rr (
    .req      (req_gated),
    .ptr      (rr_ptr),
    .lock_en  (lock_state == LOCKED),
    .lock_id  (lock_id),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  // Burst lock: keep priority on one requester until it drops lock/valid, en falls, or the burst is full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_state <= IDLE;
      lock_id    <= '0;
      burst_cnt  <= '0;
    end else begin
      case (lock_state)
        IDLE: begin
          if (accept && req_lock[grant_id] && (MAX_BURST > 1)) begin
            lock_state <= LOCKED;
            lock_id    <= grant_id;
            burst_cnt  <= BC_W'(1);
          end
        end
        LOCKED: begin
          if (!en || !req_valid[lock_id] || !req_lock[lock_id] ||
              (burst_cnt == BC_W'(MAX_BURST - 1))) begin
            lock_state <= IDLE;
            burst_cnt  <= '0;
          end else begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: lock_state <= IDLE;
      endcase
    end
  end

  // Pointer always moves past the winner, so a lock exit resumes the rotation at lock_id+1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    end
  end

  // Issue register: operands and issuer tag presented to the adder one cycle after accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_in_valid <= 1'b0;
      add_x        <= '0;
      add_y        <= '0;
      iss_id       <= '0;
    end else begin
      add_in_valid <= accept;
      if (accept) begin
        add_x  <= req_x[grant_id*VW +: VW];
        add_y  <= req_y[grant_id*VW +: VW];
        iss_id <= grant_id;
      end
    end
  end

  // Tag pipe shadows the adder so its tail lines up with add_out_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int k = 0; k < ADD_LATENCY; k++) tag_id[k] <= '0;
    end else begin
      tag_v[0]  <= add_in_valid;
      tag_id[0] <= iss_id;
      for (int k = 1; k < ADD_LATENCY; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  assign tail_v  = tag_v[ADD_LATENCY-1];
  assign tail_id = tag_id[ADD_LATENCY-1];

  // Response register; any disagreement between adder and tag pipe is latched as an orphan
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      err_orphan <= 1'b0;
    end else begin
      rsp_valid <= add_out_valid & tail_v;
      if (add_out_valid & tail_v) begin
        rsp_id   <= tail_id;
        rsp_data <= add_out;
      end
      if (add_out_valid ^ tail_v) err_orphan <= 1'b1;
    end
  end

  assign busy = add_in_valid | (|tag_v) | rsp_valid;

endmodule

// File: tb/tb_fp_vadd_arbiter.sv
// tb/tb_fp_vadd_arbiter.sv - self-checking bench for fp_vadd_arbiter with a behavioural FP12 adder
`timescale 1ns/1ps
module tb_fp_vadd_arbiter;
  import fp_pkg::*;

  localparam int NUM_REQ     = 4;
  localparam int ADD_LATENCY = 2;
  localparam int MAX_BURST   = 4;
  localparam int W           = DEF_W;
  localparam int VW          = DEF_VW;
  localparam int ID_W        = 2;

  logic                  clk       = 1'b0;
  logic                  rst_n     = 1'b0;
  logic                  en        = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_lock  = '0;
  logic [NUM_REQ*VW-1:0] req_x     = '0;
  logic [NUM_REQ*VW-1:0] req_y     = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  add_in_valid;
  logic [VW-1:0]         add_x, add_y;
  logic                  add_out_valid;
  logic [VW-1:0]         add_out;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [VW-1:0]         rsp_data;
  logic                  busy, err_orphan;
  logic                  inj = 1'b0;

  always #5 clk = ~clk;

  fp_vadd_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .ADD_LATENCY (ADD_LATENCY),
    .MAX_BURST   (MAX_BURST)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .req_valid     (req_valid),
    .req_lock      (req_lock),
    .req_x         (req_x),
    .req_y         (req_y),
    .req_ready     (req_ready),
    .add_in_valid  (add_in_valid),
    .add_x         (add_x),
    .add_y         (add_y),
    .add_out_valid (add_out_valid),
    .add_out       (add_out),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_data      (rsp_data),
    .busy          (busy),
    .err_orphan    (err_orphan)
  );

  // FP12 add for positive normal operands, truncating
  function automatic logic [W-1:0] fp_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [4:0] ea, eb;
    logic [6:0] ma, mb;
    logic [7:0] s;
    if (a[10:6] >= b[10:6]) begin
      ea = a[10:6]; ma = {1'b1, a[5:0]}; eb = b[10:6]; mb = {1'b1, b[5:0]};
    end else begin
      ea = b[10:6]; ma = {1'b1, b[5:0]}; eb = a[10:6]; mb = {1'b1, a[5:0]};
    end
    mb = mb >> (ea - eb);
    s  = {1'b0, ma} + {1'b0, mb};
    if (s[7]) return {1'b0, ea + 5'd1, s[6:1]};
    return {1'b0, ea, s[5:0]};
  endfunction

  function automatic logic [VW-1:0] vadd(input logic [VW-1:0] x, input logic [VW-1:0] y);
    logic [VW-1:0] r;
    for (int l = 0; l < 4; l++) r[l*W +: W] = fp_add(x[l*W +: W], y[l*W +: W]);
    return r;
  endfunction

  // Adder model, reset together with the arbiter
  logic [ADD_LATENCY-1:0] ap_v;
  logic [VW-1:0]          ap_d [ADD_LATENCY];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ap_v <= '0;
    end else begin
      ap_v[0] <= add_in_valid;
      ap_d[0] <= vadd(add_x, add_y);
      for (int k = 1; k < ADD_LATENCY; k++) begin
        ap_v[k] <= ap_v[k-1];
        ap_d[k] <= ap_d[k-1];
      end
    end
  end
  assign add_out_valid = ap_v[ADD_LATENCY-1] | inj;
  assign add_out       = ap_d[ADD_LATENCY-1];

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [VW-1:0]   data;
  } exp_t;

  exp_t sb[$];
  exp_t e_pop;
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   rsp_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: pop on every response, push on every accept seen just before the clock edge
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      rsp_count++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got id %0d data %0h expected no response", rsp_id, rsp_data);
      end else begin
        e_pop = sb.pop_front();
        check("sb_rsp_id", 64'(rsp_id), 64'(e_pop.id));
        check("sb_rsp_data", 64'(rsp_data), 64'(e_pop.data));
      end
    end
    #3;
    if (rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i])
          sb.push_back('{id: ID_W'(i), data: vadd(req_x[i*VW +: VW], req_y[i*VW +: VW])});
      end
    end
  end

  always @(negedge rst_n) sb.delete();

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    req_valid = '0;
    req_lock  = '0;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [VW-1:0] x, input logic [VW-1:0] y);
    req_x[i*VW +: VW] = x;
    req_y[i*VW +: VW] = y;
  endtask

  typedef struct {
    int          id;
    logic [VW-1:0] x;
    logic [VW-1:0] y;
    logic [VW-1:0] exp;
  } vec_t;

  vec_t          vt [4];
  logic [W-1:0]  vals [4];
  logic [NUM_REQ-1:0] rot_exp [5];
  logic [NUM_REQ-1:0] lock_exp [6];
  int            lat;
  int            base;
  logic          prev_rsp;

  initial begin
    vt[0] = '{2, 48'h3C0_3C0_3C0_3C0, 48'h3C0_3C0_3C0_3C0, 48'h400_400_400_400};
    vt[1] = '{0, 48'h3C0_400_420_3A0, 48'h400_3C0_3C0_3C0, 48'h420_420_440_3F0};
    vt[2] = '{3, 48'h400_400_3C0_3A0, 48'h400_420_3A0_3A0, 48'h440_450_3F0_3E0};
    vt[3] = '{1, 48'h3F0_3E0_440_3C0, 48'h3C0_3C0_3C0_400, 48'h418_410_450_420};
    vals     = '{FP12_ONE, FP12_TWO, FP12_THREE, 12'h3A0};
    rot_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    lock_exp = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0010};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_add_in_valid", 64'(add_in_valid), 64'd0);
    check("rst_add_x", 64'(add_x), 64'd0);
    check("rst_add_y", 64'(add_y), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_err_orphan", 64'(err_orphan), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    en    = 1'b1;

    // Single requests from the table, with grant, latency and data checks
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      set_req(vt[v].id, vt[v].x, vt[v].y);
      req_valid = NUM_REQ'(1) << vt[v].id;
      #1 check("tbl_ready", 64'(req_ready), 64'(NUM_REQ'(1) << vt[v].id));
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      req_valid = '0;
      while (!rsp_valid && lat < 20) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
      check("tbl_latency", 64'(lat), 64'(ADD_LATENCY + 2));
      check("tbl_rsp_id", 64'(rsp_id), 64'(vt[v].id));
      check("tbl_rsp_data", 64'(rsp_data), 64'(vt[v].exp));
    end

    // Rotation with all requesters valid
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, {4{FP12_ONE}}, {4{vals[i]}});
    base      = rsp_count;
    req_valid = '1;
    for (int b = 0; b < 5; b++) begin
      #1 check("rot_grant", 64'(req_ready), 64'(rot_exp[b]));
      @(negedge clk);
    end
    req_valid = '0;
    repeat (10) @(negedge clk);
    check("rot_rsp_count", 64'(rsp_count - base), 64'd5);

    // Burst lock on requester 1 with requester 0 competing
    do_reset();
    req_lock  = 4'b0010;
    req_valid = 4'b0010;
    for (int b = 0; b < 6; b++) begin
      #1 check("lock_grant", 64'(req_ready), 64'(lock_exp[b]));
      @(negedge clk);
      if (b == 0) req_valid = 4'b0011;
    end
    req_valid = '0;
    req_lock  = '0;
    repeat (8) @(negedge clk);

    // en low with two transfers in flight
    do_reset();
    req_valid = 4'b0011;
    #1 check("en_grant0", 64'(req_ready), 64'b0001);
    @(negedge clk);
    #1 check("en_grant1", 64'(req_ready), 64'b0010);
    @(negedge clk);
    en       = 1'b0;
    base     = rsp_count;
    prev_rsp = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1 check("en0_ready", 64'(req_ready), 64'd0);
      if (rsp_valid) check("en0_busy_during_rsp", 64'(busy), 64'd1);
      if (prev_rsp && !rsp_valid) check("en0_busy_after_last", 64'(busy), 64'd0);
      prev_rsp = rsp_valid;
      @(negedge clk);
    end
    check("en0_rsp_count", 64'(rsp_count - base), 64'd2);
    check("en0_busy_idle", 64'(busy), 64'd0);
    req_valid = '0;
    en        = 1'b1;

    // Orphan result from the adder with an empty tag pipe
    do_reset();
    @(negedge clk);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    #1 check("orphan_set", 64'(err_orphan), 64'd1);
    check("orphan_no_rsp", 64'(rsp_valid), 64'd0);
    repeat (3) @(negedge clk);
    check("orphan_sticky", 64'(err_orphan), 64'd1);
    rst_n = 1'b0;
    #1 check("orphan_cleared", 64'(err_orphan), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < NUM_REQ; i++) set_req(i, {4{vals[i]}}, {4{FP12_TWO}});
    req_valid = '1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("mid_rst_add_in_valid", 64'(add_in_valid), 64'd0);
    check("mid_rst_add_x", 64'(add_x), 64'd0);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("mid_rst_rr_ptr", 64'(req_ready), 64'b0001);
    @(negedge clk);
    req_valid = '0;
    repeat (8) @(negedge clk);
    check("mid_rst_no_orphan", 64'(err_orphan), 64'd0);

    // Everything issued must have come back
    for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
